instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 39 +++
 rtl/instr_encoder_fifo.sv | 61 ++++++
 rtl/instr_encoder.sv | 88 ++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: field widths, opcode map
// and the one-hot class decode used when words are enqueued.
package instr_encoder_pkg;

  localparam int OPC_W   = 4;
  localparam int FLD_W   = 6;
  localparam int INSTR_W = 16;
  localparam int CLS_W   = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LUI  = 4'h9,
    OP_MOV  = 4'hA,
    OP_MOVS = 4'hB,
    OP_LD   = 4'hC,
    OP_ST   = 4'hD,
    OP_RSVE = 4'hE,
    OP_RSVF = 4'hF
  } opcode_e;

  // Returns {MOV, IMM, MEM, ALU}; NOP and the reserved codes decode to zero.
  function automatic logic [CLS_W-1:0] class_decode(input logic [OPC_W-1:0] op);
    logic alu, mem, imm, mov;
    alu = ~op[3] & (op[2:0] != 3'b000);
    mem = op[3] & op[2] & ~op[1];
    imm = op[3] & ~op[2] & ~op[1];
    mov = op[3] & ~op[2] & op[1];
    return {mov, imm, mem, alu};
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: DEPTH-entry FIFO whose head word is held in an output register,
// so readers never see a combinational path from the write port.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;

  always_comb begin
    wr_ptr_next = wr_en ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = rd_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    head_next   = head_reg;
    // The new head is the word being written only when it lands in the slot
    // the read pointer moves to; otherwise it already sits in the array.
    if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = wr_data;
    end else if (count_next != '0) begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign rd_data = head_reg;
  assign count   = count_reg;

endmodule

// File: rtl/instr_encoder.sv
// Packs opcode/A/B into 16-bit instruction words, tags each with its one-hot
// class and queues them. INSTR_ENC_ILLEGAL_CHECK_EN drops reserved opcodes.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPC_W-1:0]        in_opcode,
  input  logic [FLD_W-1:0]        in_a,
  input  logic [FLD_W-1:0]        in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      instr_out,
  output logic [CLS_W-1:0]        out_class,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                       ready_en_reg;
  logic                       accept;
  logic                       wr_en;
  logic                       rd_en;
  logic [INSTR_W-1:0]         word;
  logic [CLS_W-1:0]           cls;
  logic [INSTR_W+CLS_W-1:0]   head;

  // Holds in_ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign rd_en     = out_valid & out_ready;
  assign in_ready  = ready_en_reg & ((count < CW'(DEPTH)) | rd_en);
  assign accept    = in_valid & in_ready;
  assign word      = {in_opcode, in_a, in_b};
  assign cls       = class_decode(in_opcode);

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  opcode_e opcode;
  logic    reserved;
  logic    err_reg;

  assign opcode   = opcode_e'(in_opcode);
  assign reserved = (opcode == OP_RSVE) | (opcode == OP_RSVF);
  assign wr_en    = accept & ~reserved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept & reserved;
    end
  end

  assign err = err_reg;
`else
  assign wr_en = accept;
  assign err   = 1'b0;
`endif

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + CLS_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data ({cls, word}),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count)
  );

  assign instr_out = head[INSTR_W-1:0];
  assign out_class = head[INSTR_W +: CLS_W];

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes hand-computed words,
// a forked monitor pops and compares on every output handshake.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [5:0]  in_a;
  logic [5:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr_out;
  logic [3:0]  out_class;
  logic        err;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rand_rdy = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  cls_tbl [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
                                4'h4, 4'h4, 4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0};

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .out_class (out_class),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Leaves in_valid high on return so consecutive calls are back-to-back.
  task automatic send(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                      input logic [15:0] ew, input logic [3:0] ec, input bit enq);
    bit done = 0;
    int waited = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (enq) exp_q.push_back({ec, ew});
        $display("in  op=%h a=%h b=%h expect %h/%b", op, a, b, ew, ec);
        done = 1;
      end else if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: op=%h never accepted", op);
        done = 1;
      end
      waited++;
      step();
    end
  endtask

  task automatic wait_empty();
    int k = 0;
    @(negedge clk);
    while (count != 3'd0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    logic        hold = 1'b0;
    logic [19:0] hold_v = '0;
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) chk("stable_head", 32'({out_class, instr_out}), 32'(hold_v));
        if (out_valid && out_ready) begin
          $display("out word=%h class=%b", instr_out, out_class);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h with empty scoreboard", instr_out);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", 32'(instr_out), 32'(e[15:0]));
            chk("out_class", 32'(out_class), 32'(e[19:16]));
          end
        end
        hold   = out_valid && !out_ready;
        hold_v = {out_class, instr_out};
      end
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [5:0] a;
    logic [5:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_instr_out", 32'(instr_out), 32'h0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    step();

    // Single word, one-cycle latency
    send(4'h1, 6'h2A, 6'h15, 16'h1A95, 4'b0001, 1);
    idle(0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_instr_out", 32'(instr_out), 32'h1A95);
    chk("lat_out_class", 32'(out_class), 32'b0001);
    chk("lat_count", 32'(count), 32'd1);
    step();
    wait_empty();
    step();

    // Fill to DEPTH, blocked push, then simultaneous push and pop when full
    out_ready = 1'b0;
    send(4'h2, 6'h01, 6'h02, 16'h2042, 4'b0001, 1);
    send(4'h3, 6'h3F, 6'h00, 16'h3FC0, 4'b0001, 1);
    send(4'h4, 6'h00, 6'h3F, 16'h403F, 4'b0001, 1);
    send(4'h5, 6'h15, 6'h2A, 16'h556A, 4'b0001, 1);
    in_opcode = 4'h9;
    in_a      = 6'h01;
    in_b      = 6'h01;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    step();
    @(negedge clk);
    chk("blocked_count", 32'(count), 32'd4);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({4'b0100, 16'h9041});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_push_pop_count", 32'(count), 32'd4);
    step();
    wait_empty();
    step();

    // Class sequence, back-to-back
    send(4'h8, 6'h05, 6'h0A, 16'h814A, 4'b0100, 1);
    send(4'hC, 6'h3F, 6'h3F, 16'hCFFF, 4'b0010, 1);
    send(4'hA, 6'h00, 6'h01, 16'hA001, 4'b1000, 1);
    send(4'h0, 6'h2A, 6'h15, 16'h0A95, 4'b0000, 1);
    idle(0);
    wait_empty();
    step();

    // Reserved opcodes
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    send(4'hF, 6'h00, 6'h00, 16'hF000, 4'b0000, 0);
    idle(0);
    @(negedge clk);
    chk("rsv_err_pulse", 32'(err), 32'd1);
    chk("rsv_count", 32'(count), 32'd0);
    step();
    @(negedge clk);
    chk("rsv_err_clear", 32'(err), 32'd0);
    chk("rsv_no_output", 32'(out_valid), 32'd0);
    step();
`else
    send(4'hF, 6'h00, 6'h00, 16'hF000, 4'b0000, 1);
    idle(0);
    @(negedge clk);
    chk("rsv_err_tied", 32'(err), 32'd0);
    chk("rsv_out_valid", 32'(out_valid), 32'd1);
    step();
    send(4'hE, 6'h3F, 6'h3F, 16'hEFFF, 4'b0000, 1);
    idle(0);
    wait_empty();
    step();
`endif

    // Reset with words queued
    out_ready = 1'b0;
    send(4'h1, 6'h01, 6'h01, 16'h1041, 4'b0001, 1);
    send(4'hD, 6'h02, 6'h03, 16'hD083, 4'b0010, 1);
    send(4'hB, 6'h04, 6'h05, 16'hB105, 4'b1000, 1);
    idle(0);
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd3);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    chk("no_stale_word", 32'(instr_out), 32'h0);
    step();

    // Random backpressure across many pointer wraps
    rand_rdy = 1;
    for (int i = 0; i < 10 * DEPTH + 8; i++) begin
      op = 4'(i % 14);
      a  = 6'(i * 5);
      b  = 6'(63 - i);
      send(op, a, b, {op, a, b}, cls_tbl[op], 1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(0);
    rand_rdy  = 0;
    out_ready = 1'b1;
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
